// File: rtl/fetch_stage.sv
// Instruction fetch: sequential word fetch over a req/gnt/rvalid port, a small
// {pc, instr} FIFO towards decode, and redirects that flush everything in flight.
module fetch_stage #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           WORD_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [WORD_WIDTH-1:0] mem_rdata_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
    output logic                  dec_valid_o,
    output logic [WORD_WIDTH-1:0] dec_instr_o,
    output logic [ADDR_WIDTH-1:0] dec_addr_o,
    input  logic                  dec_ready_i
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT
    } state_e;

    state_e                  state_q, state_d;
    logic                    req_q, req_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   tgt_q, tgt_d;
    logic                    tgt_pend_q, tgt_pend_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    drop_q, drop_d;
    logic [ADDR_WIDTH-1:0]   fifo_addr_q  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_addr_d  [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0]   fifo_instr_q [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0]   fifo_instr_d [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic                    grant;
    logic                    resp;
    logic                    push;
    logic                    pop;
    logic [ADDR_WIDTH-1:0]   tgt_now;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^redirect_addr_i[1:0];

    always_comb begin
        state_d      = state_q;
        req_d        = 1'b0;
        addr_d       = addr_q;
        tgt_d        = tgt_q;
        tgt_pend_d   = tgt_pend_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        fifo_addr_d  = fifo_addr_q;
        fifo_instr_d = fifo_instr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;

        tgt_now = {redirect_addr_i[ADDR_WIDTH-1:2], 2'b00};
        grant   = req_q && mem_gnt_i;
        // A response only exists while a request is outstanding (WAIT); strays are ignored.
        resp    = (state_q == S_WAIT) && mem_rvalid_i;
        push    = resp && !drop_q && !redirect_i;
        pop     = (count_q != '0) && dec_ready_i && !redirect_i;

        unique case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
                if (redirect_i) addr_d = tgt_now;
            end
            S_REQ: begin
                if (grant) begin
                    pc_d       = addr_q;
                    state_d    = S_WAIT;
                    addr_d     = tgt_pend_q ? tgt_q : addr_q + STEP;
                    drop_d     = tgt_pend_q;
                    tgt_pend_d = 1'b0;
                    if (redirect_i) begin
                        addr_d = tgt_now;
                        drop_d = 1'b1;
                    end
                end else if (redirect_i) begin
                    // A request already on the bus must stay stable; park the target.
                    if (req_q) begin
                        tgt_pend_d = 1'b1;
                        tgt_d      = tgt_now;
                    end else begin
                        addr_d = tgt_now;
                    end
                end
            end
            S_WAIT: begin
                if (resp) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                end else if (redirect_i) begin
                    drop_d = 1'b1;
                end
                if (redirect_i) addr_d = tgt_now;
            end
            default: state_d = S_BOOT;
        endcase

        if (redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_addr_d[wr_ptr_q]  = pc_q;
                fifo_instr_d[wr_ptr_q] = mem_rdata_i;
                wr_ptr_d               = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        // In REQ nothing is outstanding, so only buffered entries count against space.
        req_d = (state_d == S_REQ) && (count_d < DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            req_q      <= 1'b0;
            addr_q     <= RESET_ADDR;
            tgt_q      <= '0;
            tgt_pend_q <= 1'b0;
            pc_q       <= '0;
            drop_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i]  <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            tgt_q        <= tgt_d;
            tgt_pend_q   <= tgt_pend_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            fifo_addr_q  <= fifo_addr_d;
            fifo_instr_q <= fifo_instr_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_addr_o  = addr_q;
    assign dec_valid_o = (count_q != '0);
    assign dec_instr_o = fifo_instr_q[rd_ptr_q];
    assign dec_addr_o  = fifo_addr_q[rd_ptr_q];

    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (mem_req_o && !mem_gnt_i) |=> (mem_req_o && $stable(mem_addr_o)));
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= DEPTH_C);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed timing scenarios plus a randomized run checked
// against a program-order stream model (pc advances by 4, redirect restarts it).
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        dec_ready_i;

    logic        mem_req_o, dec_valid_o;
    logic [31:0] mem_addr_o, dec_instr_o, dec_addr_o;
    logic        h_mem_req_o, h_dec_valid_o;
    logic [31:0] h_mem_addr_o, h_dec_instr_o, h_dec_addr_o;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_ADDR(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .dec_valid_o(dec_valid_o), .dec_instr_o(dec_instr_o), .dec_addr_o(dec_addr_o),
        .dec_ready_i(dec_ready_i)
    );

    fetch_stage #(.RESET_ADDR(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut_hi (
        .clk(clk), .rst_n(rst_n),
        .mem_req_o(h_mem_req_o), .mem_addr_o(h_mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .dec_valid_o(h_dec_valid_o), .dec_instr_o(h_dec_instr_o), .dec_addr_o(h_dec_addr_o),
        .dec_ready_i(dec_ready_i)
    );

    int checks = 0;
    int errors = 0;

    // Memory responder state (tracks the low-address instance).
    bit          pend;
    logic [31:0] pend_addr;
    int          gnt_mode;   // 0 low, 1 high, 2 random
    int          rv_mode;    // 0 never, 1 next cycle, 2 random

    logic [31:0] grants[$];
    logic [31:0] got_a[$], got_i[$];
    logic [31:0] hgot_a[$], hgot_i[$];

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic tick();
        bit          g, r, live, d, hd;
        logic [31:0] ga, da, di, ha, hi;
        live = rst_n;
        g  = live && mem_req_o && mem_gnt_i;
        ga = mem_addr_o;
        r  = mem_rvalid_i;
        d  = live && dec_valid_o && dec_ready_i && !redirect_i;
        da = dec_addr_o;
        di = dec_instr_o;
        hd = live && h_dec_valid_o && dec_ready_i && !redirect_i;
        ha = h_dec_addr_o;
        hi = h_dec_instr_o;
        @(posedge clk);
        #1;
        if (!live) pend = 1'b0;
        else begin
            if (r) pend = 1'b0;
            if (g) begin
                pend = 1'b1;
                pend_addr = ga;
                grants.push_back(ga);
            end
        end
        if (d) begin got_a.push_back(da); got_i.push_back(di); end
        if (hd) begin hgot_a.push_back(ha); hgot_i.push_back(hi); end
        case (gnt_mode)
            0:       mem_gnt_i = 1'b0;
            1:       mem_gnt_i = 1'b1;
            default: mem_gnt_i = 1'($urandom % 2);
        endcase
        mem_rvalid_i = pend && (rv_mode == 1 || (rv_mode == 2 && ($urandom % 3) == 0));
        mem_rdata_i  = f(pend_addr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_i = 1'b0;
        redirect_addr_i = '0;
        dec_ready_i = 1'b0;
        gnt_mode = 0;
        rv_mode = 0;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        repeat (3) tick();
        grants.delete(); got_a.delete(); got_i.delete(); hgot_a.delete(); hgot_i.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        tick();
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 00000000", mem_addr_o); end
        checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dec_valid_o); end
        checks++; if (dec_instr_o !== 32'h0 || dec_addr_o !== 32'h0) begin
            errors++; $display("FAIL reset_dec got %h/%h exp 0/0", dec_instr_o, dec_addr_o); end
        checks++; if (h_mem_addr_o !== 32'hFFFF_FFF8 || h_mem_req_o !== 1'b0) begin
            errors++; $display("FAIL reset_hi_addr got %h req %b exp fffffff8 req 0", h_mem_addr_o, h_mem_req_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_seq();
        int first;
        logic [31:0] e;
        do_reset();
        gnt_mode = 1; mem_gnt_i = 1'b1; rv_mode = 1; dec_ready_i = 1'b1;
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (dec_valid_o && first < 0) first = i;
        end
        checks++; if (first != 3) begin errors++; $display("FAIL seq_first_valid got %0d exp 3", first); end
        checks++; if (got_a.size() < 4 || grants.size() < 4) begin
            errors++; $display("FAIL seq_count got %0d/%0d exp >=4", got_a.size(), grants.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                e = 32'(4 * k);
                checks++;
                if (got_a[k] !== e || got_i[k] !== f(e) || grants[k] !== e) begin
                    errors++;
                    $display("FAIL seq_item%0d got %h/%h gnt %h exp %h/%h", k, got_a[k], got_i[k], grants[k], e, f(e));
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ea;
        do_reset();
        gnt_mode = 1; mem_gnt_i = 1'b1; rv_mode = 1; dec_ready_i = 1'b1;
        repeat (12) tick();
        checks++; if (hgot_a.size() < 3) begin errors++; $display("FAIL wrap_count got %0d exp >=3", hgot_a.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                ea = 32'hFFFF_FFF8 + 32'(4 * k);
                checks++;
                // Shared rdata comes from the low instance's fetch of address 4*k.
                if (hgot_a[k] !== ea || hgot_i[k] !== f(32'(4 * k))) begin
                    errors++; $display("FAIL wrap_item%0d got %h/%h exp %h/%h", k, hgot_a[k], hgot_i[k], ea, f(32'(4 * k)));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        gnt_mode = 1; mem_gnt_i = 1'b1; rv_mode = 1; dec_ready_i = 1'b0;
        repeat (12) tick();
        checks++; if (grants.size() != 2) begin errors++; $display("FAIL bp_grants got %0d exp 2", grants.size()); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL bp_req got %b exp 0", mem_req_o); end
        checks++; if (dec_valid_o !== 1'b1 || dec_addr_o !== 32'h0 || dec_instr_o !== f(32'h0)) begin
            errors++; $display("FAIL bp_head got %b %h/%h exp 1 00000000/%h", dec_valid_o, dec_addr_o, dec_instr_o, f(32'h0)); end
        dec_ready_i = 1'b1;
        repeat (12) tick();
        checks++; if (got_a.size() < 3 || grants.size() < 3) begin
            errors++; $display("FAIL bp_resume_count got %0d/%0d exp >=3", got_a.size(), grants.size()); end
        else begin
            checks++; if (got_a[0] !== 32'h0 || got_a[1] !== 32'h4 || got_a[2] !== 32'h8) begin
                errors++; $display("FAIL bp_order got %h %h %h exp 0 4 8", got_a[0], got_a[1], got_a[2]); end
            checks++; if (grants[0] !== 32'h0 || grants[1] !== 32'h4 || grants[2] !== 32'h8) begin
                errors++; $display("FAIL bp_fetch got %h %h %h exp 0 4 8", grants[0], grants[1], grants[2]); end
        end
    endtask

    task automatic test_held_redirect();
        do_reset();
        gnt_mode = 0; rv_mode = 1; dec_ready_i = 1'b1;
        tick();
        tick();
        redirect_i = 1'b1; redirect_addr_i = 32'h0000_0103;
        tick();
        redirect_i = 1'b0;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            errors++; $display("FAIL held_after_redir got %b %h exp 1 00000000", mem_req_o, mem_addr_o); end
        tick();
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            errors++; $display("FAIL held_still got %b %h exp 1 00000000", mem_req_o, mem_addr_o); end
        gnt_mode = 1; mem_gnt_i = 1'b1;
        tick();
        checks++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h100) begin
            errors++; $display("FAIL held_next_addr got %b %h exp 0 00000100", mem_req_o, mem_addr_o); end
        repeat (12) tick();
        checks++; if (got_a.size() < 1 || grants.size() < 2) begin
            errors++; $display("FAIL held_count got %0d/%0d exp >=1/>=2", got_a.size(), grants.size()); end
        else begin
            checks++; if (got_a[0] !== 32'h100 || got_i[0] !== f(32'h100)) begin
                errors++; $display("FAIL held_first got %h/%h exp 00000100/%h", got_a[0], got_i[0], f(32'h100)); end
            checks++; if (grants[0] !== 32'h0 || grants[1] !== 32'h100) begin
                errors++; $display("FAIL held_fetch got %h %h exp 0 100", grants[0], grants[1]); end
        end
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        gnt_mode = 1; mem_gnt_i = 1'b1; rv_mode = 1; dec_ready_i = 1'b0;
        repeat (4) tick();
        checks++; if (dec_valid_o !== 1'b1 || mem_rvalid_i !== 1'b1) begin
            errors++; $display("FAIL rr_setup got valid %b rvalid %b exp 1 1", dec_valid_o, mem_rvalid_i); end
        redirect_i = 1'b1; redirect_addr_i = 32'h0000_0200;
        tick();
        redirect_i = 1'b0;
        checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL rr_flush got %b exp 0", dec_valid_o); end
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin
            errors++; $display("FAIL rr_next got %b %h exp 1 00000200", mem_req_o, mem_addr_o); end
        dec_ready_i = 1'b1;
        repeat (12) tick();
        checks++; if (got_a.size() < 2) begin errors++; $display("FAIL rr_count got %0d exp >=2", got_a.size()); end
        else begin
            checks++; if (got_a[0] !== 32'h200 || got_i[0] !== f(32'h200) || got_a[1] !== 32'h204) begin
                errors++; $display("FAIL rr_stream got %h/%h %h exp 00000200/%h 00000204", got_a[0], got_i[0], got_a[1], f(32'h200)); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        gnt_mode = 1; mem_gnt_i = 1'b1; rv_mode = 0; dec_ready_i = 1'b1;
        tick();
        tick();
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rm_wait got %b exp 0", mem_req_o); end
        rst_n = 1'b0; gnt_mode = 0; mem_gnt_i = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        tick();
        checks++; if (dec_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            errors++; $display("FAIL rm_restart got %b %b %h exp 0 1 00000000", dec_valid_o, mem_req_o, mem_addr_o); end
        grants.delete(); got_a.delete(); got_i.delete();
        gnt_mode = 1; mem_gnt_i = 1'b1; rv_mode = 1;
        tick();
        checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL rm_no_early got %b exp 0", dec_valid_o); end
        repeat (6) tick();
        checks++; if (got_a.size() < 1 || grants.size() < 1) begin
            errors++; $display("FAIL rm_count got %0d/%0d exp >=1", got_a.size(), grants.size()); end
        else begin
            checks++; if (got_a[0] !== 32'h0 || got_i[0] !== f(32'h0) || grants[0] !== 32'h0) begin
                errors++; $display("FAIL rm_first got %h/%h gnt %h exp 00000000/%h", got_a[0], got_i[0], grants[0], f(32'h0)); end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, haddr;
        bit          hold, was_redir;
        int          n_deliv;
        do_reset();
        gnt_mode = 2; rv_mode = 2;
        exp_pc = 32'h0;
        n_deliv = 0;
        for (int c = 0; c < 3000; c++) begin
            dec_ready_i = ($urandom % 4) != 0;
            redirect_i  = ($urandom % 16) == 0;
            if (redirect_i) begin
                redirect_addr_i = $urandom & 32'h0000_3FFF;
                if (($urandom % 4) == 0) redirect_addr_i = redirect_addr_i | 32'hFFFF_C000;
            end
            if (!pend && ($urandom % 10) == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = 32'hBAD0_0BAD;
            end
            if (dec_valid_o && dec_ready_i && !redirect_i) begin
                checks++;
                if (dec_addr_o !== exp_pc || dec_instr_o !== f(exp_pc)) begin
                    errors++;
                    $display("FAIL rnd_stream c%0d got %h/%h exp %h/%h", c, dec_addr_o, dec_instr_o, exp_pc, f(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
            end
            if (redirect_i) exp_pc = redirect_addr_i & 32'hFFFF_FFFC;
            hold      = mem_req_o && !mem_gnt_i;
            haddr     = mem_addr_o;
            was_redir = redirect_i;
            tick();
            redirect_i = 1'b0;
            if (hold) begin
                checks++;
                if (mem_req_o !== 1'b1 || mem_addr_o !== haddr) begin
                    errors++; $display("FAIL rnd_hold c%0d got %b %h exp 1 %h", c, mem_req_o, mem_addr_o, haddr);
                end
            end
            if (was_redir) begin
                checks++;
                if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL rnd_flush c%0d got %b exp 0", c, dec_valid_o); end
            end
            if (pend) begin
                checks++;
                if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rnd_single_out c%0d got %b exp 0", c, mem_req_o); end
            end
        end
        checks++;
        if (n_deliv < 50) begin errors++; $display("FAIL rnd_progress got %0d exp >=50", n_deliv); end
    endtask

    initial begin
        rst_n = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        redirect_i = 1'b0; redirect_addr_i = '0; dec_ready_i = 1'b0;
        pend = 1'b0; pend_addr = '0; gnt_mode = 0; rv_mode = 0;
        test_reset();
        test_seq();
        test_wrap();
        test_backpressure();
        test_held_redirect();
        test_redirect_rvalid();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
